// File: rtl/divisor_frequencia.sv
// divisor_frequencia
// Multi-channel programmable clock divider. Each channel counts enabled
// clk edges modulo its own divisor D and produces a one-cycle tick at every
// wrap (pulso) and a wave that is high for the upper half of the period (onda).
// Divisor writes to a running channel go to a shadow register and are only
// adopted at the next wrap, so a period is never cut short or stretched.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   habilita  per-channel enable; 0 parks the channel at c=0 with outputs low
//   carga     one-cycle strobe writing valor into channel sel
//   sel       target channel for carga; values >= CANAIS are ignored
//   valor     new divisor (0 and 1 are stored as 2)
//   pulso     per-channel tick, high in the c=0 cycle that follows a wrap
//   onda      per-channel wave, high while c >= floor(D/2)
//   pendente  per-channel flag: a shadow divisor is waiting for the next wrap

module divisor_frequencia #(
    parameter int                 CANAIS     = 2,
    parameter int                 LARGURA    = 26,
    parameter logic [LARGURA-1:0] DIV_PADRAO = 26'd50000000
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [CANAIS-1:0]                         habilita,
    input  logic                                      carga,
    input  logic [$clog2(CANAIS > 1 ? CANAIS : 2)-1:0] sel,
    input  logic [LARGURA-1:0]                        valor,
    output logic [CANAIS-1:0]                         pulso,
    output logic [CANAIS-1:0]                         onda,
    output logic [CANAIS-1:0]                         pendente
);

    localparam int SEL_W = $clog2(CANAIS > 1 ? CANAIS : 2);

    logic [LARGURA-1:0] valor_clamp;

    assign valor_clamp = (valor < LARGURA'(2)) ? LARGURA'(2) : valor;

    for (genvar i = 0; i < CANAIS; i++) begin : g_canal
        logic [LARGURA-1:0] c;
        logic [LARGURA-1:0] d;
        logic [LARGURA-1:0] dp;
        logic               pend_r;
        logic               pulso_r;
        logic               onda_r;

        logic [LARGURA-1:0] c_n;
        logic [LARGURA-1:0] d_n;
        logic [LARGURA-1:0] dp_n;
        logic               pend_n;
        logic               pulso_n;
        logic               onda_n;
        logic               wrap;
        logic               load;

        // An out-of-range sel never equals any channel index, so such loads
        // simply land nowhere.
        assign load = carga && (sel == SEL_W'(i));
        assign wrap = (c == d - LARGURA'(1));

        always_comb begin
            c_n     = c;
            d_n     = d;
            dp_n    = dp;
            pend_n  = pend_r;
            pulso_n = 1'b0;
            onda_n  = 1'b0;
            if (habilita[i]) begin
                pulso_n = wrap;
                if (wrap) begin
                    c_n = '0;
                    if (pend_r) begin
                        d_n    = dp;
                        pend_n = 1'b0;
                    end
                end else begin
                    c_n = c + LARGURA'(1);
                end
                // A load on the wrap edge must not be consumed by that wrap:
                // it overrides the flag clear and waits for the next one.
                if (load) begin
                    dp_n   = valor_clamp;
                    pend_n = 1'b1;
                end
                // Decode from the next-state counter and divisor so the
                // registered outputs line up with c in the same cycle.
                onda_n = (c_n >= (d_n >> 1));
            end else begin
                c_n = '0;
                if (load) begin
                    d_n    = valor_clamp;
                    dp_n   = valor_clamp;
                    pend_n = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c       <= '0;
                d       <= DIV_PADRAO;
                dp      <= DIV_PADRAO;
                pend_r  <= 1'b0;
                pulso_r <= 1'b0;
                onda_r  <= 1'b0;
            end else begin
                c       <= c_n;
                d       <= d_n;
                dp      <= dp_n;
                pend_r  <= pend_n;
                pulso_r <= pulso_n;
                onda_r  <= onda_n;
            end
        end

        assign pulso[i]    = pulso_r;
        assign onda[i]     = onda_r;
        assign pendente[i] = pend_r;
    end

endmodule
